// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared widths, owner tags and command type for the video RAM arbiter
package vram_pkg;

  localparam int VRAM_ADDR_W = 19;
  localparam int VRAM_DATA_W = 9;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_HOST = 2'd2
  } owner_t;

  typedef struct packed {
    logic                   en;
    logic                   we;
    logic [VRAM_ADDR_W-1:0] addr;
    logic [VRAM_DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/vram_tag_pipe.sv
// rtl/vram_tag_pipe.sv - owner tag delay line aligning each read with its returning RAM data
module vram_tag_pipe
  import vram_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  owner_t tag_in,
  output owner_t tag_out
);

  owner_t stage_q [DEPTH];
  owner_t stage_d [DEPTH];

  always_comb begin
    stage_d[0] = tag_in;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= OWN_NONE;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - display-priority arbiter for the single-port video RAM
// with a bounded host starvation override and per-owner read data steering.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W     = VRAM_ADDR_W,
  parameter int DATA_W     = VRAM_DATA_W,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_override,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
  localparam logic [CNT_W-1:0] STARVE_LAST = CNT_W'((STARVE_MAX > 0) ? STARVE_MAX - 1 : 0);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  mem_cmd_t         mem_cmd_q, mem_cmd_d;
  owner_t           tag_in, tag_out;
  logic             force_host, disp_win, host_win;

  always_comb begin
    force_host = !rst && host_req && disp_req && (STARVE_MAX > 0) && (starve_cnt_q == STARVE_LAST);
    disp_win   = !rst && disp_req && !force_host;
    host_win   = !rst && host_req && (force_host || !disp_req);

    // Counter only climbs while the host is actively being refused.
    starve_cnt_d = starve_cnt_q;
    if (!host_req || host_win) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != STARVE_LAST) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end

    mem_cmd_d    = mem_cmd_q;
    mem_cmd_d.en = 1'b0;
    mem_cmd_d.we = 1'b0;
    tag_in       = OWN_NONE;
    if (disp_win) begin
      mem_cmd_d.en   = 1'b1;
      mem_cmd_d.addr = disp_addr;
      tag_in         = OWN_DISP;
    end else if (host_win) begin
      mem_cmd_d.en    = 1'b1;
      mem_cmd_d.we    = host_we;
      mem_cmd_d.addr  = host_addr;
      mem_cmd_d.wdata = host_wdata;
      tag_in          = host_we ? OWN_NONE : OWN_HOST;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
      mem_cmd_q    <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      mem_cmd_q    <= mem_cmd_d;
    end
  end

  vram_tag_pipe #(
    .DEPTH (1 + RD_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Reads still in flight when reset arrives must never surface.
  assign disp_rvalid   = !rst && (tag_out == OWN_DISP);
  assign host_rvalid   = !rst && (tag_out == OWN_HOST);
  assign disp_rdata    = disp_rvalid ? mem_rdata : '0;
  assign host_rdata    = host_rvalid ? mem_rdata : '0;

  assign disp_gnt      = disp_win;
  assign host_gnt      = host_win;
  assign host_override = force_host;

  assign mem_en        = mem_cmd_q.en;
  assign mem_we        = mem_cmd_q.we;
  assign mem_addr      = mem_cmd_q.addr;
  assign mem_wdata     = mem_cmd_q.wdata;

endmodule
